// File: rtl/bomberman_pkg.sv
// rtl/bomberman_pkg.sv - shared video geometry, sprite1 mover types and axis fit helper (SPRITE_WRAP_EN selects wrap vs clamp)
package bomberman_pkg;

    localparam int HACTIVE      = 800;
    localparam int VACTIVE      = 600;
    localparam int R            = 50;
    localparam int SPEED_MIN    = 1;
    localparam int SPEED_MAX    = 8;
    localparam int ACCEL_FRAMES = 4;

    typedef logic signed [10:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        STEP_X,
        STEP_Y,
        COMMIT
    } mover_state_t;

    // Bring a 12-bit candidate coordinate back into [lo, hi]: saturate by default,
    // jump to the opposite bound when wrapping is built in.
    function automatic coord_t fit_axis(input logic signed [11:0] v, input int lo, input int hi);
        logic signed [11:0] lo_s;
        logic signed [11:0] hi_s;
        coord_t             res;
        lo_s = 12'(lo);
        hi_s = 12'(hi);
        res  = v[10:0];
`ifdef SPRITE_WRAP_EN
        if (v < lo_s) begin
            res = hi_s[10:0];
        end else if (v > hi_s) begin
            res = lo_s[10:0];
        end
`else
        if (v < lo_s) begin
            res = lo_s[10:0];
        end else if (v > hi_s) begin
            res = hi_s[10:0];
        end
`endif
        return res;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop synchroniser for asynchronous button inputs
module btn_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives the clean, clk-aligned copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sprite1_mover.sv
// rtl/sprite1_mover.sv - per-frame sprite1 centre controller with speed ramp and edge clamp (SPRITE_WRAP_EN enables wrap)
module sprite1_mover
    import bomberman_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    output logic signed [10:0] centerX,
    output logic signed [10:0] centerY,
    output logic               moving
);

    localparam logic [3:0] SPD_MIN = 4'(SPEED_MIN);
    localparam logic [3:0] SPD_MAX = 4'(SPEED_MAX);
    localparam logic [2:0] ACCEL_N = 3'(ACCEL_FRAMES);

    // Bit order everywhere: {up, down, left, right}
    logic [3:0]   btn_s;
    logic [3:0]   btn_q;
    logic [3:0]   speed;
    logic [2:0]   hold_cnt;
    logic [2:0]   hold_inc;
    coord_t       nx;
    coord_t       ny;
    mover_state_t state;
    mover_state_t state_next;

    logic signed [11:0] x_sum;
    logic signed [11:0] y_sum;
    logic signed [11:0] spd_ext;

    btn_sync #(.WIDTH(4)) u_btn_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({btn_up, btn_down, btn_left, btn_right}),
        .q       (btn_s)
    );

    // State register; a reset mid-sequence simply drops the in-flight update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fixed walk through the update; frame_start only matters while idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = LATCH;
            LATCH:   state_next = STEP_X;
            STEP_X:  state_next = STEP_Y;
            STEP_Y:  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Candidate coordinates: opposite buttons cancel, otherwise step by the current speed.
    always_comb begin
        hold_inc = hold_cnt + 3'd1;
        spd_ext  = {8'd0, speed};
        x_sum    = {centerX[10], centerX};
        y_sum    = {centerY[10], centerY};
        if (btn_q[0] && !btn_q[1]) begin
            x_sum = x_sum + spd_ext;
        end else if (btn_q[1] && !btn_q[0]) begin
            x_sum = x_sum - spd_ext;
        end
        if (btn_q[2] && !btn_q[3]) begin
            y_sum = y_sum + spd_ext;
        end else if (btn_q[3] && !btn_q[2]) begin
            y_sum = y_sum - spd_ext;
        end
    end

    // Datapath: latch buttons and ramp speed, fit X then Y, then publish both at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q    <= '0;
            speed    <= SPD_MIN;
            hold_cnt <= '0;
            nx       <= 11'(HACTIVE / 2);
            ny       <= 11'(VACTIVE / 2);
            centerX  <= 11'(HACTIVE / 2);
            centerY  <= 11'(VACTIVE / 2);
            moving   <= 1'b0;
        end else begin
            case (state)
                LATCH: begin
                    btn_q <= btn_s;
                    if (|btn_s) begin
                        if (hold_inc == ACCEL_N) begin
                            hold_cnt <= '0;
                            if (speed < SPD_MAX) begin
                                speed <= speed + 4'd1;
                            end
                        end else begin
                            hold_cnt <= hold_inc;
                        end
                    end else begin
                        speed    <= SPD_MIN;
                        hold_cnt <= '0;
                    end
                end
                STEP_X: nx <= fit_axis(x_sum, R, HACTIVE - 1 - R);
                STEP_Y: ny <= fit_axis(y_sum, R, VACTIVE - 1 - R);
                COMMIT: begin
                    centerX <= nx;
                    centerY <= ny;
                    moving  <= (nx != centerX) || (ny != centerY);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite1_mover.sv
// tb/tb_sprite1_mover.sv - directed self-checking bench for sprite1_mover
module tb_sprite1_mover;

    logic               clk;
    logic               reset_n;
    logic               frame_start;
    logic               btn_up;
    logic               btn_down;
    logic               btn_left;
    logic               btn_right;
    logic signed [10:0] centerX;
    logic signed [10:0] centerY;
    logic               moving;

    int checks;
    int errors;

    sprite1_mover dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .centerX     (centerX),
        .centerY     (centerY),
        .moving      (moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset_n     = 1'b0;
        frame_start = 1'b0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        btn_left    = 1'b0;
        btn_right   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        btn_up    = u;
        btn_down  = d;
        btn_left  = l;
        btn_right = r;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (centerX !== 11'sd400) begin errors++; $display("FAIL reset_x: got %0d want 400", centerX); end
        checks++;
        if (centerY !== 11'sd300) begin errors++; $display("FAIL reset_y: got %0d want 300", centerY); end
        checks++;
        if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving: got %b want 0", moving); end
        for (int f = 0; f < 3; f++) begin
            run_frame();
            checks++;
            if (centerX !== 11'sd400 || centerY !== 11'sd300 || moving !== 1'b0) begin
                errors++;
                $display("FAIL idle_frame%0d: got (%0d,%0d,%b) want (400,300,0)", f, centerX, centerY, moving);
            end
        end
    endtask

    task automatic test_ramp();
        int exp_x [5] = '{401, 402, 403, 405, 407};
        int prev;
        apply_reset();
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        prev = 400;
        for (int f = 0; f < 5; f++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                checks++;
                if (centerX !== 11'(prev)) begin
                    errors++;
                    $display("FAIL ramp_early f%0d clk%0d: got %0d want %0d", f, k + 1, centerX, prev);
                end
            end
            @(negedge clk);
            checks++;
            if (centerX !== 11'(exp_x[f]) || centerY !== 11'sd300 || moving !== 1'b1) begin
                errors++;
                $display("FAIL ramp_commit f%0d: got (%0d,%0d,%b) want (%0d,300,1)", f, centerX, centerY, moving, exp_x[f]);
            end
            prev = exp_x[f];
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_opposite();
        apply_reset();
        set_btn(1'b0, 1'b1, 1'b1, 1'b1);
        run_frame();
        checks++;
        if (centerX !== 11'sd400 || centerY !== 11'sd301 || moving !== 1'b1) begin
            errors++;
            $display("FAIL opposite: got (%0d,%0d,%b) want (400,301,1)", centerX, centerY, moving);
        end
    endtask

    task automatic test_clamp();
        apply_reset();
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        run_frames(27);
        checks++;
        if (centerX !== 11'sd511) begin errors++; $display("FAIL clamp_ramp27: got %0d want 511", centerX); end
        run_frames(28);
        checks++;
        if (centerX !== 11'sd735) begin errors++; $display("FAIL clamp_ramp55: got %0d want 735", centerX); end
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        run_frame();
        checks++;
        if (centerX !== 11'sd735 || moving !== 1'b0) begin
            errors++;
            $display("FAIL clamp_release: got (%0d,%b) want (735,0)", centerX, moving);
        end
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        run_frames(2);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        run_frame();
        checks++;
        if (centerX !== 11'sd737) begin errors++; $display("FAIL clamp_nudge: got %0d want 737", centerX); end
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        run_frames(7);
        checks++;
        if (centerX !== 11'sd748) begin errors++; $display("FAIL clamp_pre: got %0d want 748", centerX); end
        run_frame();
`ifdef SPRITE_WRAP_EN
        checks++;
        if (centerX !== 11'sd50 || moving !== 1'b1) begin
            errors++;
            $display("FAIL wrap_hit: got (%0d,%b) want (50,1)", centerX, moving);
        end
        run_frame();
        checks++;
        if (centerX !== 11'sd53 || moving !== 1'b1) begin
            errors++;
            $display("FAIL wrap_after: got (%0d,%b) want (53,1)", centerX, moving);
        end
`else
        checks++;
        if (centerX !== 11'sd749 || moving !== 1'b1) begin
            errors++;
            $display("FAIL clamp_hit: got (%0d,%b) want (749,1)", centerX, moving);
        end
        run_frame();
        checks++;
        if (centerX !== 11'sd749 || centerY !== 11'sd300 || moving !== 1'b0) begin
            errors++;
            $display("FAIL clamp_hold: got (%0d,%0d,%b) want (749,300,0)", centerX, centerY, moving);
        end
`endif
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (centerX !== 11'sd401) begin errors++; $display("FAIL b2b_single: got %0d want 401", centerX); end
        run_frame();
        checks++;
        if (centerX !== 11'sd402) begin errors++; $display("FAIL b2b_next: got %0d want 402", centerX); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        run_frames(4);
        checks++;
        if (centerX !== 11'sd405) begin errors++; $display("FAIL mid_pre: got %0d want 405", centerX); end
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (centerX !== 11'sd400 || centerY !== 11'sd300 || moving !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got (%0d,%0d,%b) want (400,300,0)", centerX, centerY, moving);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (centerX !== 11'sd400 || moving !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet: got (%0d,%b) want (400,0)", centerX, moving);
        end
        run_frame();
        checks++;
        if (centerX !== 11'sd401 || moving !== 1'b1) begin
            errors++;
            $display("FAIL mid_resume: got (%0d,%b) want (401,1)", centerX, moving);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ramp();
        test_opposite();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
